fetch_stage: RTL

//   Instruction-fetch stage of the 5-stage pipelined MIPS core. Owns the program counter,

---
 rtl/mips_pkg.sv | 34 +++
 rtl/ifid_reg.sv | 53 +++++
 rtl/fetch_stage.sv | 103 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips_pkg
// Purpose  : Shared constants and IF/ID record type for the 5-stage MIPS core.
//            Reused by fetch, decode and the hazard unit.
// Contents : ADDR_W   - instruction address width (word addressed)
//            INST_W   - instruction word width
//            NOP_WORD - encoding placed in IF/ID on a bubble or flush
//            if_id_t  - {inst, pc_plus1, valid}
//            pc_inc   - PC + 1, wrapping modulo 2^ADDR_W
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam int ADDR_W = 12;
  localparam int INST_W = 19;

  localparam logic [INST_W-1:0] NOP_WORD = 19'h00000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc_plus1;
    logic              valid;
  } if_id_t;

  // Truncation to ADDR_W bits gives the 0xFFF -> 0x000 wrap for free.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_reg.sv
//------------------------------------------------------------------------------
// Module   : ifid_reg
// Purpose  : IF/ID pipeline register with squash and hold controls.
//            Squash has priority over hold: a squashed register always loads
//            the bubble (NOP_WORD, pc_plus1 = 0, valid = 0).
// Ports    : clk       in   clock, rising edge
//            rst       in   asynchronous active-high reset (loads the bubble)
//            i_squash  in   load bubble next edge
//            i_hold    in   keep current contents next edge
//            i_inst    in   fetched instruction word
//            i_pc_plus1 in  PC+1 of the fetched word
//            o_inst    out  registered instruction
//            o_pc_plus1 out registered PC+1
//            o_valid   out  registered valid flag
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifid_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_squash,
  input  logic              i_hold,
  input  logic [INST_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_pc_plus1,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc_plus1,
  output logic              o_valid
);

  localparam if_id_t c_bubble = '{inst: NOP_WORD, pc_plus1: '0, valid: 1'b0};

  if_id_t r_ifid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid <= c_bubble;
    end else if (i_squash) begin
      r_ifid <= c_bubble;
    end else if (!i_hold) begin
      r_ifid <= '{inst: i_inst, pc_plus1: i_pc_plus1, valid: 1'b1};
    end
  end

  assign o_inst     = r_ifid.inst;
  assign o_pc_plus1 = r_ifid.pc_plus1;
  assign o_valid    = r_ifid.valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage of the 5-stage MIPS core. Owns the PC,
//            drives the combinational instruction-memory address and captures
//            the returned word into the IF/ID register. Handles stall, flush
//            and EX-stage branch/jump redirect.
// Ports    : clk, rst         clock / asynchronous active-high reset
//            imem_addr        out  current PC (combinational)
//            imem_data        in   instruction word for imem_addr, same cycle
//            stall            in   hold PC and IF/ID
//            flush            in   squash IF/ID next edge
//            redirect_valid   in   taken branch / jump from EX
//            redirect_pc      in   redirect target
//            ifid_inst        out  registered instruction to decode
//            ifid_pc_plus1    out  registered PC+1 of that instruction
//            ifid_valid       out  ifid_inst is a real fetched instruction
//            perf_fetch_cnt   out  instructions loaded into IF/ID
//            perf_bubble_cnt  out  edges that loaded a bubble
// Config   : FETCH_PERF_CNT_EN - when defined, adds the two performance
//            counter ports and registers; otherwise they are absent.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] ifid_inst,
  output logic [ADDR_W-1:0] ifid_pc_plus1,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt,
`endif
  output logic              ifid_valid
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic              w_squash;

  assign w_pc_plus1 = pc_inc(r_pc);
  // A redirect kills the wrong-path word currently being fetched.
  assign w_squash   = redirect_valid | flush;
  assign imem_addr  = r_pc;

  // Redirect overrides stall so a taken branch is never lost behind a hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (!stall) begin
      r_pc <= w_pc_plus1;
    end
  end

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .i_squash   (w_squash),
    .i_hold     (stall),
    .i_inst     (imem_data),
    .i_pc_plus1 (w_pc_plus1),
    .o_inst     (ifid_inst),
    .o_pc_plus1 (ifid_pc_plus1),
    .o_valid    (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic        w_load_valid;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  // Same condition under which ifid_reg loads valid<=1.
  assign w_load_valid = ~w_squash & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_load_valid) r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (w_squash)     r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt  = r_fetch_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

`default_nettype wire
